// File: rtl/product_accumulator_pkg.sv
// Shared types and defaults for the product accumulator: FSM state encoding,
// default widths, and the counter-width helper.
package product_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int DEF_PROD_W = 4;
    localparam int DEF_ACC_W  = 8;
    localparam int DEF_COUNT  = 4;

    // Beat counter needs at least one bit even when COUNT is 1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive unsigned products into one result and presents it on a
// valid/ready output with a sticky per-result overflow flag.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int COUNT  = DEF_COUNT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output state_e            o_dbg_state
);

    // Handshake rule on both sides: a transfer happens on a rising edge where
    // valid && ready are both high; ready never looks at valid, and a valid
    // source holds its payload stable until the transfer completes.

    localparam int CNT_W = cnt_width(COUNT);

    state_e             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_ovf;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_last;
    logic [ACC_W:0]     w_sum_ext;
    logic               w_carry;

    assign w_accept  = in_valid && (r_state == ACCUM);
    assign w_last    = (r_cnt == CNT_W'(COUNT - 1));
    // One extra bit on the adder captures the carry out of ACC_W.
    assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    assign w_carry   = w_sum_ext[ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_out_sum   <= w_sum_ext[ACC_W-1:0];
                            r_out_ovf   <= r_ovf | w_carry;
                            r_out_valid <= 1'b1;
                            r_state     <= HOLD;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_ovf       <= 1'b0;
                        end else begin
                            r_acc <= w_sum_ext[ACC_W-1:0];
                            r_ovf <= r_ovf | w_carry;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign in_ready    = (r_state == ACCUM);
    assign out_valid   = r_out_valid;
    assign out_sum     = r_out_sum;
    assign out_ovf     = r_out_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed scoreboard bench: a default-width instance and an ACC_W=5 instance
// share stimulus; each has its own expected-result queue and monitor.
module tb_product_accumulator;
    import product_accumulator_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [3:0] drv_product;
    logic       use_mul;
    logic [1:0] mul_a;
    logic [1:0] mul_b;
    logic [3:0] in_product;
    logic       out_ready;

    logic       rdy8, vld8, ovf8;
    logic [7:0] sum8;
    state_e     st8;
    logic       rdy5, vld5, ovf5;
    logic [4:0] sum5;
    state_e     st5;

    logic [8:0] exp_q8[$];
    logic [5:0] exp_q5[$];

    int n_vec;
    int n_err;

    // Bench-level stand-in for the upstream 2-bit multiplier.
    assign in_product = use_mul ? ({2'b00, mul_a} * {2'b00, mul_b}) : drv_product;

    product_accumulator #(.PROD_W(4), .ACC_W(8), .COUNT(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy8), .in_product(in_product),
        .out_valid(vld8), .out_ready(out_ready), .out_sum(sum8), .out_ovf(ovf8),
        .o_dbg_state(st8)
    );

    product_accumulator #(.PROD_W(4), .ACC_W(5), .COUNT(4)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy5), .in_product(in_product),
        .out_valid(vld5), .out_ready(out_ready), .out_sum(sum5), .out_ovf(ovf5),
        .o_dbg_state(st5)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drivers
    task automatic send_beat(input logic [3:0] p);
        int waited;
        waited = 0;
        in_valid    = 1'b1;
        drv_product = p;
        while (!rdy8 && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL in_ready_timeout: in_ready stuck at 0, expected 1 within 50 cycles");
        end
        tick();
        in_valid    = 1'b0;
        drv_product = 'x;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_result(input logic [7:0] s8, input logic o8,
                                 input logic [4:0] s5, input logic o5);
        exp_q8.push_back({o8, s8});
        exp_q5.push_back({o5, s5});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid8"}, {31'd0, vld8}, 0);
        check({tag, "_sum8"},   {24'd0, sum8}, 0);
        check({tag, "_ovf8"},   {31'd0, ovf8}, 0);
        check({tag, "_ready8"}, {31'd0, rdy8}, 1);
        check({tag, "_valid5"}, {31'd0, vld5}, 0);
        check({tag, "_ready5"}, {31'd0, rdy5}, 1);
    endtask

    // Scoreboard monitors: a result is consumed on the edge after a negedge
    // that sees out_valid && out_ready.
    always @(negedge clk) begin
        if (rst_n && !clear && vld8 && out_ready) begin
            n_vec++;
            if (exp_q8.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result8: got sum %0d ovf %0d, expected none", sum8, ovf8);
            end else begin
                logic [8:0] e;
                e = exp_q8.pop_front();
                if ({ovf8, sum8} !== e) begin
                    n_err++;
                    $display("FAIL result8: got sum %0d ovf %0d, expected sum %0d ovf %0d",
                             sum8, ovf8, e[7:0], e[8]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !clear && vld5 && out_ready) begin
            n_vec++;
            if (exp_q5.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result5: got sum %0d ovf %0d, expected none", sum5, ovf5);
            end else begin
                logic [5:0] e;
                e = exp_q5.pop_front();
                if ({ovf5, sum5} !== e) begin
                    n_err++;
                    $display("FAIL result5: got sum %0d ovf %0d, expected sum %0d ovf %0d",
                             sum5, ovf5, e[4:0], e[5]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        clear       = 1'b0;
        in_valid    = 1'b0;
        drv_product = '0;
        use_mul     = 1'b0;
        mul_a       = '0;
        mul_b       = '0;
        out_ready   = 1'b1;

        #2;
        check_idle_outputs("reset");
        #10 rst_n = 1'b1;
        tick();

        // Streaming frame 9,4,6,1 -> 20
        expect_result(8'd20, 1'b0, 5'd20, 1'b0);
        send_beat(4'd9);
        send_beat(4'd4);
        send_beat(4'd6);
        check("pre_last_valid", {31'd0, vld8}, 0);
        send_beat(4'd1);
        check("latency_valid", {31'd0, vld8}, 1);
        check("latency_sum", {24'd0, sum8}, 20);
        check("hold_in_ready", {31'd0, rdy8}, 0);
        check("hold_state", {31'd0, st8}, {31'd0, HOLD});
        tick();
        check("post_hs_valid", {31'd0, vld8}, 0);
        check("post_hs_in_ready", {31'd0, rdy8}, 1);

        // Backpressure: result 10 held while next product waits
        out_ready = 1'b0;
        expect_result(8'd10, 1'b0, 5'd10, 1'b0);
        send_beat(4'd1);
        send_beat(4'd2);
        send_beat(4'd3);
        send_beat(4'd4);
        in_valid    = 1'b1;
        drv_product = 4'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'd0, vld8}, 1);
            check("bp_sum", {24'd0, sum8}, 10);
            check("bp_in_ready", {31'd0, rdy8}, 0);
        end
        out_ready = 1'b1;
        expect_result(8'd8, 1'b0, 5'd8, 1'b0);
        send_beat(4'd5);
        send_beat(4'd1);
        send_beat(4'd1);
        send_beat(4'd1);
        tick();

        // Bubbles: 2,_,3,_,_,4,1 -> 10
        expect_result(8'd10, 1'b0, 5'd10, 1'b0);
        send_beat(4'd2);
        idle(1);
        send_beat(4'd3);
        idle(2);
        send_beat(4'd4);
        check("bubble_no_early_valid", {31'd0, vld8}, 0);
        send_beat(4'd1);
        tick();

        // Overflow: 9x4 = 36 -> 36 on 8 bits, 4 with carry on 5 bits
        expect_result(8'd36, 1'b0, 5'd4, 1'b1);
        for (int i = 0; i < 4; i++) send_beat(4'd9);
        tick();
        expect_result(8'd4, 1'b0, 5'd4, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(4'd1);
        tick();

        // Clear mid-frame, with a beat presented alongside clear being dropped
        send_beat(4'd9);
        send_beat(4'd9);
        clear       = 1'b1;
        in_valid    = 1'b1;
        drv_product = 4'd7;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        expect_result(8'd4, 1'b0, 5'd4, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(4'd1);
        tick();

        // Clear during HOLD: result discarded without handshake
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(4'd2);
        check("clr_hold_valid_before", {31'd0, vld8}, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_hold_valid_after", {31'd0, vld8}, 0);
        check("clr_hold_in_ready", {31'd0, rdy8}, 1);
        check("clr_hold_valid5_after", {31'd0, vld5}, 0);
        out_ready = 1'b1;

        // Async reset mid-frame, off the clock edge
        send_beat(4'd5);
        send_beat(4'd5);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("arst_frame");
        #2 rst_n = 1'b1;
        tick();

        // Async reset mid-HOLD
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(4'd2);
        check("arst_hold_valid_before", {31'd0, vld8}, 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("arst_hold");
        #2 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        expect_result(8'd12, 1'b0, 5'd12, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(4'd3);
        tick();

        // Integration: multiplier a=b=2 repeated four times -> 16
        use_mul = 1'b1;
        mul_a   = 2'd2;
        mul_b   = 2'd2;
        expect_result(8'd16, 1'b0, 5'd16, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(4'd0);
        tick();
        use_mul = 1'b0;

        // Drain: every expected result must have been observed
        for (int i = 0; i < 20 && (exp_q8.size() != 0 || exp_q5.size() != 0); i++) tick();
        check("drain_q8", exp_q8.size(), 0);
        check("drain_q5", exp_q5.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
